mipi_image_extractor: RTL and testbench

MIPI_IMAGE_EXTRACTOR -- requirements
Module: mipi_image_extractor

---
 rtl/mipi_pkg.sv | 24 ++
 rtl/mipi_header_parser.sv | 53 +++++
 rtl/mipi_image_extractor.sv | 224 ++++++++++++++++++++++
 tb/tb_mipi_image_extractor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_pkg.sv
// Shared CSI-2 constants and the packet FSM state type for the image extractor.
package mipi_pkg;

    // Short-packet data types that carry frame framing information
    localparam logic [7:0] DT_FS       = 8'h00;
    localparam logic [7:0] DT_FE       = 8'h01;
    // Byte the transmitter may emit between packets; never a header start
    localparam logic [7:0] DT_FILLER   = 8'hFF;
    // Data types at or above this value are long packets with a payload
    localparam logic [7:0] DT_LONG_MIN = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    // True when the data type announces a long packet (payload follows the header)
    function automatic logic is_long_packet(input logic [7:0] dt);
        return (dt >= DT_LONG_MIN);
    endfunction

endpackage

// File: rtl/mipi_header_parser.sv
// Captures the 4-byte CSI-2 packet header: data type, 16-bit word count
// (LSB first) and the ECC byte, which is consumed but not checked.
module mipi_header_parser
    import mipi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,      // header byte 0 (data type) consumed
    input  logic        i_hdr_byte,   // a header byte 1..3 consumed
    input  logic [7:0]  i_data,
    output logic [7:0]  o_dt,
    output logic [15:0] o_word_count,
    output logic        o_hdr_done    // header byte 3 consumed this cycle
);

    logic [7:0]  r_dt;
    logic [15:0] r_word_count;
    logic [1:0]  r_idx;   // 0: expecting WC LSB, 1: WC MSB, 2: ECC

    // Header field capture, restarted by every new data-type byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dt         <= 8'h00;
            r_word_count <= 16'h0000;
            r_idx        <= 2'd0;
        end else if (i_start) begin
            r_dt  <= i_data;
            r_idx <= 2'd0;
        end else if (i_hdr_byte) begin
            case (r_idx)
                2'd0: begin
                    r_word_count[7:0] <= i_data;
                    r_idx             <= 2'd1;
                end
                2'd1: begin
                    r_word_count[15:8] <= i_data;
                    r_idx              <= 2'd2;
                end
                // ECC byte: not stored, header is complete
                default: begin
                    r_idx <= 2'd0;
                end
            endcase
        end else begin
            r_idx <= r_idx;
        end
    end

    assign o_dt         = r_dt;
    assign o_word_count = r_word_count;
    assign o_hdr_done   = i_hdr_byte && (r_idx == 2'd2);

endmodule

// File: rtl/mipi_image_extractor.sv
// Parses a CSI-2 byte stream into packets, forwards every long-packet payload
// byte on pixel_data and the payload of accepted image lines on line_data,
// while tracking frame boundaries and the number of lines in the frame.
module mipi_image_extractor
    import mipi_pkg::*;
#(
    parameter logic [7:0] IMAGE_DT    = 8'h2C,
    parameter int         FRAME_LINES = 800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mipi_data,
    input  logic       mipi_data_valid,
    input  logic       mipi_read_enable,
    input  logic       dma_ready,
    output logic [7:0] pixel_data,
    output logic       pixel_data_valid,
    output logic [7:0] line_data,
    output logic       line_valid,
    output logic       frame_valid,
    output logic       new_frame,
    output logic       row_done,
    output logic       frame_done
);

    localparam logic [15:0] LP_FRAME_LINES = 16'(FRAME_LINES);

    state_t      r_state;
    state_t      w_state_next;

    logic        w_consume;
    logic        w_hdr_start;
    logic        w_hdr_byte;
    logic        w_hdr_done;
    logic [7:0]  w_dt;
    logic [15:0] w_word_count;

    logic        w_short_done;
    logic        w_long_start;
    logic        w_payload_byte;
    logic        w_payload_last;

    logic [15:0] r_byte_cnt;
    logic [15:0] r_line_cnt;
    logic        r_line_acc;

    logic [7:0]  r_pixel_data;
    logic        r_pixel_valid;
    logic [7:0]  r_line_data;
    logic        r_line_valid;
    logic        r_frame_valid;
    logic        r_new_frame;
    logic        r_row_done;
    logic        r_frame_done;

    assign w_consume   = mipi_data_valid && mipi_read_enable;
    assign w_hdr_start = (r_state == ST_IDLE) && w_consume && (mipi_data != DT_FILLER);
    assign w_hdr_byte  = (r_state == ST_HEADER) && w_consume;

    mipi_header_parser u_header_parser (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_hdr_start),
        .i_hdr_byte   (w_hdr_byte),
        .i_data       (mipi_data),
        .o_dt         (w_dt),
        .o_word_count (w_word_count),
        .o_hdr_done   (w_hdr_done)
    );

    // Packet FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Packet FSM next state and per-cycle event strobes
    always_comb begin
        w_state_next   = r_state;
        w_short_done   = 1'b0;
        w_long_start   = 1'b0;
        w_payload_byte = 1'b0;
        w_payload_last = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_start) begin
                    w_state_next = ST_HEADER;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (!mipi_data_valid) begin
                    // link dropped to LP mid-header: abandon the packet
                    w_state_next = ST_IDLE;
                end else if (w_hdr_done) begin
                    if (is_long_packet(w_dt)) begin
                        w_long_start = 1'b1;
                        if (w_word_count == 16'd0) begin
                            w_state_next = ST_DRAIN;
                        end else begin
                            w_state_next = ST_PAYLOAD;
                        end
                    end else begin
                        w_short_done = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_HEADER;
                end
            end
            ST_PAYLOAD: begin
                if (!mipi_data_valid) begin
                    // truncated payload: bytes already forwarded stand, no row_done
                    w_state_next = ST_IDLE;
                end else if (w_consume) begin
                    w_payload_byte = 1'b1;
                    if (r_byte_cnt == 16'd1) begin
                        w_payload_last = 1'b1;
                        w_state_next   = ST_DRAIN;
                    end else begin
                        w_state_next = ST_PAYLOAD;
                    end
                end else begin
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_DRAIN: begin
                // surplus bytes (e.g. packet footer) are discarded until LP
                if (!mipi_data_valid) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, frame/line bookkeeping and payload byte counting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pixel_data  <= 8'h00;
            r_pixel_valid <= 1'b0;
            r_line_data   <= 8'h00;
            r_line_valid  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_new_frame   <= 1'b0;
            r_row_done    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_byte_cnt    <= 16'h0000;
            r_line_cnt    <= 16'h0000;
            r_line_acc    <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_line_valid  <= 1'b0;
            r_new_frame   <= 1'b0;
            r_row_done    <= 1'b0;
            r_frame_done  <= 1'b0;

            if (w_short_done) begin
                if (w_dt == DT_FS) begin
                    // a frame start inside a frame simply restarts it
                    r_new_frame   <= 1'b1;
                    r_frame_valid <= 1'b1;
                    r_line_cnt    <= 16'h0000;
                end else if (w_dt == DT_FE) begin
                    r_frame_done  <= r_frame_valid;
                    r_frame_valid <= 1'b0;
                end else begin
                    r_frame_valid <= r_frame_valid;
                end
            end

            if (w_long_start) begin
                r_byte_cnt <= w_word_count;
                // acceptance is decided once per line; later dma_ready changes are ignored
                r_line_acc <= (w_dt == IMAGE_DT) && r_frame_valid && dma_ready;
            end else if (w_payload_byte) begin
                r_byte_cnt <= r_byte_cnt - 16'd1;
            end else begin
                r_byte_cnt <= r_byte_cnt;
            end

            if (w_payload_byte) begin
                r_pixel_data  <= mipi_data;
                r_pixel_valid <= 1'b1;
                if (r_line_acc) begin
                    r_line_data  <= mipi_data;
                    r_line_valid <= 1'b1;
                    if (w_payload_last) begin
                        r_row_done <= 1'b1;
                        r_line_cnt <= r_line_cnt + 16'd1;
                        if ((r_line_cnt + 16'd1) == LP_FRAME_LINES) begin
                            r_frame_done  <= 1'b1;
                            r_frame_valid <= 1'b0;
                        end else begin
                            r_frame_done <= 1'b0;
                        end
                    end else begin
                        r_row_done <= 1'b0;
                    end
                end else begin
                    r_line_valid <= 1'b0;
                end
            end
        end
    end

    assign pixel_data       = r_pixel_data;
    assign pixel_data_valid = r_pixel_valid;
    assign line_data        = r_line_data;
    assign line_valid       = r_line_valid;
    assign frame_valid      = r_frame_valid;
    assign new_frame        = r_new_frame;
    assign row_done         = r_row_done;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_mipi_image_extractor.sv
// Self-checking bench: drives CSI-2 packets and compares the observed output
// streams against a packet-level reference model.
module tb_mipi_image_extractor;

    localparam logic [7:0] IMG_DT = 8'h2C;
    localparam int         FL     = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mipi_data;
    logic       mipi_data_valid;
    logic       mipi_read_enable;
    logic       dma_ready;
    logic [7:0] pixel_data;
    logic       pixel_data_valid;
    logic [7:0] line_data;
    logic       line_valid;
    logic       frame_valid;
    logic       new_frame;
    logic       row_done;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    // reference model state (packet level)
    logic [7:0] exp_pix[$];
    logic [7:0] exp_line[$];
    int         exp_rowlen[$];
    int         exp_fd[$];
    int         exp_nf = 0;
    bit         m_fv   = 1'b0;
    int         m_cnt  = 0;
    int         m_pend = 0;

    // observed streams
    logic [7:0] got_pix[$];
    logic [7:0] got_line[$];
    int         got_rowlen[$];
    int         got_fd[$];
    int         got_nf   = 0;
    int         mon_pend = 0;
    logic       rst_q;

    mipi_image_extractor #(
        .IMAGE_DT    (IMG_DT),
        .FRAME_LINES (FL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mipi_data        (mipi_data),
        .mipi_data_valid  (mipi_data_valid),
        .mipi_read_enable (mipi_read_enable),
        .dma_ready        (dma_ready),
        .pixel_data       (pixel_data),
        .pixel_data_valid (pixel_data_valid),
        .line_data        (line_data),
        .line_valid       (line_valid),
        .frame_valid      (frame_valid),
        .new_frame        (new_frame),
        .row_done         (row_done),
        .frame_done       (frame_done)
    );

    always #5 clk = ~clk;

    // remember whether the last rising edge was a reset edge
    always @(posedge clk) rst_q <= rst;

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        int p;
        p = mon_pend;
        if (pixel_data_valid === 1'b1) got_pix.push_back(pixel_data);
        if (line_valid === 1'b1) begin
            got_line.push_back(line_data);
            p = p + 1;
        end
        if (row_done === 1'b1) begin
            got_rowlen.push_back((line_valid === 1'b1) ? p : -1);
            p = 0;
        end
        if (frame_done === 1'b1) got_fd.push_back((row_done === 1'b1) ? 1 : 0);
        if (new_frame === 1'b1) got_nf <= got_nf + 1;
        if (rst_q === 1'b1) p = 0;
        mon_pend <= p;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_byte(input logic [7:0] b, input int stall);
        bit done;
        done = 1'b0;
        mipi_data       = b;
        mipi_data_valid = 1'b1;
        for (int t = 0; t < 16 && !done; t++) begin
            mipi_read_enable = (t < 15 && $urandom_range(99) < stall) ? 1'b0 : 1'b1;
            done = mipi_read_enable;
            @(negedge clk);
        end
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            mipi_data_valid  = 1'b0;
            mipi_read_enable = 1'(($urandom_range(1)));
            mipi_data        = 8'($urandom);
            @(negedge clk);
        end
    endtask

    // one packet: fill FF bytes, n_hdr header bytes, n_pay payload bytes, LP gap
    task automatic send_packet(input logic [7:0] dt, input int wc, input int n_hdr, input int n_pay,
                               input bit dma, input bit wiggle, input int stall, input int fill,
                               input bit ramp, input int pause_at);
        logic [7:0] hdr [4];
        logic [7:0] b;
        bit acc;
        for (int i = 0; i < fill; i++) put_byte(8'hFF, 0);
        dma_ready = dma;
        hdr[0] = dt;
        hdr[1] = wc[7:0];
        hdr[2] = wc[15:8];
        hdr[3] = 8'($urandom);
        for (int i = 0; i < n_hdr; i++) put_byte(hdr[i], stall);
        if (n_hdr == 4) begin
            if (dt < 8'h10) begin
                if (dt == 8'h00) begin
                    exp_nf++;
                    m_fv  = 1'b1;
                    m_cnt = 0;
                end else if (dt == 8'h01) begin
                    if (m_fv) exp_fd.push_back(0);
                    m_fv = 1'b0;
                end
            end else begin
                acc = (dt == IMG_DT) && m_fv && dma;
                for (int i = 0; i < n_pay; i++) begin
                    if (i == pause_at) begin
                        mipi_data_valid  = 1'b1;
                        mipi_read_enable = 1'b0;
                        for (int s = 0; s < 5; s++) begin
                            @(negedge clk);
                            check("pause_no_output", pixel_data_valid, 1'b0);
                        end
                    end
                    b = ramp ? 8'(i) : 8'($urandom);
                    if (wiggle) dma_ready = 1'(($urandom_range(1)));
                    put_byte(b, stall);
                    if (i < wc) begin
                        exp_pix.push_back(b);
                        if (acc) exp_line.push_back(b);
                    end
                end
                if (acc && wc > 0) begin
                    if (n_pay >= wc) begin
                        exp_rowlen.push_back(m_pend + wc);
                        m_pend = 0;
                        m_cnt++;
                        if (m_cnt == FL) begin
                            exp_fd.push_back(1);
                            m_fv = 1'b0;
                        end
                    end else begin
                        m_pend += n_pay;
                    end
                end
            end
        end
        gap(2);
    endtask

    task automatic compare_all(input string tag);
        int nbad;
        check({tag, "/pix_n"}, got_pix.size(), exp_pix.size());
        nbad = 0;
        for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++)
            if (got_pix[i] !== exp_pix[i]) nbad++;
        check({tag, "/pix_data_bad"}, nbad, 0);
        check({tag, "/line_n"}, got_line.size(), exp_line.size());
        nbad = 0;
        for (int i = 0; i < got_line.size() && i < exp_line.size(); i++)
            if (got_line[i] !== exp_line[i]) nbad++;
        check({tag, "/line_data_bad"}, nbad, 0);
        check({tag, "/row_done_n"}, got_rowlen.size(), exp_rowlen.size());
        nbad = 0;
        for (int i = 0; i < got_rowlen.size() && i < exp_rowlen.size(); i++)
            if (got_rowlen[i] !== exp_rowlen[i]) nbad++;
        check({tag, "/row_len_bad"}, nbad, 0);
        check({tag, "/frame_done_n"}, got_fd.size(), exp_fd.size());
        nbad = 0;
        for (int i = 0; i < got_fd.size() && i < exp_fd.size(); i++)
            if (got_fd[i] !== exp_fd[i]) nbad++;
        check({tag, "/frame_done_bad"}, nbad, 0);
        check({tag, "/new_frame_n"}, got_nf, exp_nf);
        check({tag, "/frame_valid"}, frame_valid, m_fv);
    endtask

    initial begin
        rst              = 1'b1;
        mipi_data        = 8'h00;
        mipi_data_valid  = 1'b0;
        mipi_read_enable = 1'b0;
        dma_ready        = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_pixel_valid", pixel_data_valid, 1'b0);
        check("rst_line_valid", line_valid, 1'b0);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_pulses", {new_frame, row_done, frame_done}, 3'b000);
        check("rst_pixel_data", pixel_data, 8'h00);
        check("rst_line_data", line_data, 8'h00);
        rst = 1'b0;
        gap(2);

        // frame start packet, then filler bytes
        dma_ready = 1'b1;
        put_byte(8'h00, 0);
        put_byte(8'h01, 0);
        put_byte(8'h00, 0);
        put_byte(8'h1A, 0);
        check("fs_new_frame_pulse", new_frame, 1'b1);
        check("fs_frame_valid", frame_valid, 1'b1);
        exp_nf++;
        m_fv  = 1'b1;
        m_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            put_byte(8'hFF, 0);
            check("filler_quiet", {new_frame, pixel_data_valid, line_valid}, 3'b000);
        end
        gap(2);
        compare_all("fs_filler");

        // image line with 10 surplus bytes
        send_packet(8'h2C, 1280, 4, 1290, 1'b1, 1'b0, 0, 0, 1'b1, -1);
        compare_all("line_surplus");

        // downstream not ready at the header
        send_packet(8'h2C, 1280, 4, 1280, 1'b0, 1'b0, 0, 0, 1'b1, -1);
        compare_all("dma_low");

        // read-enable pause mid-line plus random stalls and dma toggling
        send_packet(8'h2C, 1280, 4, 1280, 1'b1, 1'b1, 20, 2, 1'b1, 640);
        compare_all("stall_line");

        // frame line limit: new frame, more lines than the frame holds
        send_packet(8'h00, 0, 4, 0, 1'b1, 1'b0, 0, 1, 1'b0, -1);
        for (int i = 0; i < FL + 3; i++)
            send_packet(8'h2C, 16, 4, 16, 1'b1, 1'b0, 0, 0, 1'b0, -1);
        compare_all("frame_limit");

        // randomized packet mix
        send_packet(8'h00, 0, 4, 0, 1'b1, 1'b0, 0, 0, 1'b0, -1);
        for (int k = 0; k < 60; k++) begin
            int sel;
            int wc;
            int np;
            logic [7:0] dt;
            sel = $urandom_range(11);
            wc  = $urandom_range(1, 40);
            np  = wc + $urandom_range(0, 4);
            dt  = 8'h2C;
            case (sel)
                0: begin dt = 8'h00; wc = $urandom_range(65535); end
                1: begin dt = 8'h01; wc = $urandom_range(65535); end
                2: begin dt = 8'h05; wc = $urandom_range(65535); end
                3: dt = 8'h2B;
                4: begin wc = 0; np = $urandom_range(0, 3); end
                5: np = $urandom_range(0, wc - 1);
                default: dt = 8'h2C;
            endcase
            if (sel == 6)
                send_packet(dt, wc, $urandom_range(1, 3), np, 1'b1, 1'b0, 10, 1, 1'b0, -1);
            else
                send_packet(dt, wc, 4, np, 1'(($urandom_range(3) != 0)), 1'b1,
                            $urandom_range(0, 30), $urandom_range(0, 3), 1'b0, -1);
            compare_all("random");
        end

        // reset in the middle of an accepted line
        send_packet(8'h00, 0, 4, 0, 1'b1, 1'b0, 0, 0, 1'b0, -1);
        dma_ready = 1'b1;
        put_byte(8'h2C, 0);
        put_byte(8'h00, 0);
        put_byte(8'h05, 0);
        put_byte(8'h13, 0);
        for (int i = 0; i < 100; i++) begin
            put_byte(8'(i), 0);
            exp_pix.push_back(8'(i));
            exp_line.push_back(8'(i));
        end
        rst             = 1'b1;
        mipi_data_valid = 1'b0;
        @(negedge clk);
        check("midrst_outputs", {pixel_data_valid, line_valid, frame_valid, new_frame, row_done, frame_done},
              6'b000000);
        check("midrst_data", {pixel_data, line_data}, 16'h0000);
        rst    = 1'b0;
        m_fv   = 1'b0;
        m_cnt  = 0;
        m_pend = 0;
        send_packet(8'h2C, 1280, 4, 1280, 1'b1, 1'b0, 0, 0, 1'b1, -1);
        compare_all("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
